// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : product_accumulator
// Brief    : Sums a burst of unsigned multiplier products into a guarded
//            accumulator; presents the total, term count and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int PROD_W = 128,
  parameter int GUARD  = 8,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = PROD_W + GUARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_in_ready;

  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_accept;

  always_comb begin
    w_sum       = {1'b0, r_acc} + {1'b0, {GUARD{1'b0}}, in_prod};
    w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    w_accept    = (r_state == ST_ACC) && r_in_ready && in_valid;
  end

  // in_ready is its own register so it stays low through reset and only
  // rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACC;
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_ACC;
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_sum[ACC_W];
            if (in_last) begin
              r_state    <= ST_HOLD;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          r_in_ready <= 1'b0;
          if (out_ready) begin
            r_state    <= ST_ACC;
            r_acc      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_ACC;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_accumulator
// Brief    : Directed self-checking bench for product_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

  localparam int PROD_W = 128;
  localparam int ACC_W  = 136;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PROD_W-1:0] all_ones;
  logic [ACC_W-1:0]  exp_wrap;

  product_accumulator #(.PROD_W(PROD_W), .GUARD(8), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one product for exactly one edge, then idles the input.
  task automatic beat(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = '0;
  endtask

  initial begin
    all_ones = '1;
    exp_wrap = (ACC_W'(1) << PROD_W) - ACC_W'(257);

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_prod = 128'd77;
    in_last = 1'b1; out_ready = 1'b1;
    #7;
    check("rst_out_valid", ACC_W'(out_valid), '0);
    check("rst_in_ready",  ACC_W'(in_ready),  '0);
    check("rst_acc",       out_acc,           '0);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
    tick();
    check("post_rst_in_ready",  ACC_W'(in_ready),  ACC_W'(1));
    check("post_rst_out_valid", ACC_W'(out_valid), '0);

    // Basic burst
    beat(128'd5, 1'b0);
    beat(128'd7, 1'b0);
    beat(128'h100, 1'b1);
    check("basic_valid",    ACC_W'(out_valid), ACC_W'(1));
    check("basic_acc",      out_acc,           ACC_W'('h10C));
    check("basic_count",    ACC_W'(out_count), ACC_W'(3));
    check("basic_ovf",      ACC_W'(out_ovf),   '0);
    check("basic_bubble",   ACC_W'(in_ready),  '0);
    tick();
    check("basic_done_valid", ACC_W'(out_valid), '0);
    check("basic_ready_back", ACC_W'(in_ready),  ACC_W'(1));

    // Backpressure
    out_ready = 1'b0;
    beat(128'd5, 1'b0);
    beat(128'd7, 1'b0);
    beat(128'h100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid",    ACC_W'(out_valid), ACC_W'(1));
      check("bp_acc",      out_acc,           ACC_W'('h10C));
      check("bp_count",    ACC_W'(out_count), ACC_W'(3));
      check("bp_in_ready", ACC_W'(in_ready),  '0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", ACC_W'(out_valid), '0);
    check("bp_release_ready", ACC_W'(in_ready),  ACC_W'(1));
    check("bp_cleared_acc",   out_acc,           '0);
    check("bp_cleared_count", ACC_W'(out_count), '0);

    // Single-term burst of the largest product
    beat(all_ones, 1'b1);
    check("single_valid", ACC_W'(out_valid), ACC_W'(1));
    check("single_acc",   out_acc,           ACC_W'(all_ones));
    check("single_count", ACC_W'(out_count), ACC_W'(1));
    check("single_ovf",   ACC_W'(out_ovf),   '0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Overflow and count saturation
    for (int i = 0; i < 257; i++) begin
      beat(all_ones, (i == 256));
      if (i == 254)
        check("sat_count_255", ACC_W'(out_count), ACC_W'(255));
    end
    check("ovf_valid", ACC_W'(out_valid), ACC_W'(1));
    check("ovf_acc",   out_acc,           exp_wrap);
    check("ovf_count", ACC_W'(out_count), ACC_W'(255));
    check("ovf_flag",  ACC_W'(out_ovf),   ACC_W'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ovf_flag_cleared", ACC_W'(out_ovf), '0);

    // Clear mid-burst drops the concurrent product
    beat(128'd3, 1'b0);
    beat(128'd4, 1'b0);
    check("pre_clear_acc", out_acc, ACC_W'(7));
    clear = 1'b1;
    beat(128'd9, 1'b0);
    clear = 1'b0;
    check("clear_acc",       out_acc,           '0);
    check("clear_count",     ACC_W'(out_count), '0);
    check("clear_in_ready",  ACC_W'(in_ready),  ACC_W'(1));
    beat(128'd6, 1'b1);
    check("after_clear_valid", ACC_W'(out_valid), ACC_W'(1));
    check("after_clear_acc",   out_acc,           ACC_W'(6));
    check("after_clear_count", ACC_W'(out_count), ACC_W'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_hold_valid", ACC_W'(out_valid), '0);
    check("clear_hold_acc",   out_acc,           '0);

    // Asynchronous reset while holding a result
    beat(128'd11, 1'b1);
    check("pre_async_valid", ACC_W'(out_valid), ACC_W'(1));
    rst_n = 1'b0;
    #1;
    check("async_valid",    ACC_W'(out_valid), '0);
    check("async_in_ready", ACC_W'(in_ready),  '0);
    check("async_acc",      out_acc,           '0);
    check("async_count",    ACC_W'(out_count), '0);
    rst_n = 1'b1;
    tick();
    check("async_rel_ready", ACC_W'(in_ready), ACC_W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
